// File: rtl/chirp_sched.sv
// chirp_sched: pulse sequencer feeding the chirp DDS a profile over a 4-phase REQ/ACK handshake, then timing start/gap.
// Optional handshake timeout: define CHIRP_SCHED_ACK_TIMEOUT_EN.
module chirp_sched #(
    parameter int N_PROF = 4,
    parameter int CW     = 24,
    parameter int ACK_TO = 1024
) (
    input  logic                      clk_48,
    input  logic                      rst_n,
    input  logic                      cfg_we,
    input  logic [$clog2(N_PROF)-1:0] cfg_addr,
    input  logic [47:0]               cfg_freq,
    input  logic [47:0]               cfg_dfreq,
    input  logic [31:0]               cfg_rate,
    input  logic [$clog2(N_PROF):0]   n_prof,
    input  logic [15:0]               burst_cnt,
    input  logic [CW-1:0]             pulse_len,
    input  logic [CW-1:0]             gap_len,
    input  logic                      go,
    input  logic                      abort,
    output logic                      REQ,
    input  logic                      ACK,
    output logic [47:0]               DDS_freq,
    output logic [47:0]               DDS_delta_freq,
    output logic [31:0]               DDS_delta_rate,
    output logic                      start,
    output logic                      busy,
    output logic                      done,
    output logic [15:0]               pulse_idx,
    output logic                      err
);

    localparam int PW = $clog2(N_PROF);

    if (N_PROF < 2 || (N_PROF & (N_PROF - 1)) != 0 || CW < 2 || ACK_TO < 2) begin : g_bad_params
        $error("chirp_sched: illegal parameter set");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_REQ_HI,
        S_REQ_LO,
        S_PULSE,
        S_GAP,
        S_DONE,
        S_DRAIN
    } state_t;

    state_t state, next_state;

    logic [47:0]   freq_tab  [N_PROF];
    logic [47:0]   dfreq_tab [N_PROF];
    logic [31:0]   rate_tab  [N_PROF];

    logic [PW:0]   lat_nprof;
    logic [15:0]   lat_burst;
    logic [CW-1:0] lat_pulse;
    logic [CW-1:0] lat_gap;
    logic [CW-1:0] len_cnt;
    logic [PW-1:0] prof_idx;
    logic [PW-1:0] prof_adv;

    logic [PW:0]   eff_nprof;
    logic [CW-1:0] eff_pulse;
    logic [CW-1:0] eff_gap;
    logic [15:0]   pulse_next;
    logic          last_pulse;
    logic          go_ok;
    logic          gap_end;
    logic          to_hit;

    // Clamp the control inputs once, at the point they are latched.
    always_comb begin
        eff_nprof = n_prof;
        if (n_prof == '0)
            eff_nprof = (PW+1)'(1);
        else if (n_prof > (PW+1)'(N_PROF))
            eff_nprof = (PW+1)'(N_PROF);
        eff_pulse = (pulse_len < CW'(2)) ? CW'(2) : pulse_len;
        eff_gap   = (gap_len   < CW'(2)) ? CW'(2) : gap_len;
    end

    assign pulse_next = pulse_idx + 16'd1;
    assign last_pulse = (lat_burst != 16'd0) && (pulse_next == lat_burst);
    assign prof_adv   = ({1'b0, prof_idx} == lat_nprof - (PW+1)'(1)) ? '0 : prof_idx + PW'(1);
    assign go_ok      = (state == S_IDLE) && (next_state == S_LOAD);
    assign gap_end    = (state == S_GAP) && (next_state inside {S_LOAD, S_DONE});

    // NOTE: every variable assigned in always_comb gets a default first; a path that
    // leaves one unassigned would infer a latch.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:   if (go && !abort) next_state = S_LOAD;
            S_LOAD:   next_state = abort ? S_IDLE : S_REQ_HI;
            S_REQ_HI: begin
                if (abort)       next_state = S_DRAIN;
                else if (to_hit) next_state = S_IDLE;
                else if (ACK)    next_state = S_REQ_LO;
            end
            S_REQ_LO: begin
                if (abort)       next_state = S_DRAIN;
                else if (to_hit) next_state = S_IDLE;
                else if (!ACK)   next_state = S_PULSE;
            end
            S_PULSE: begin
                if (abort)                 next_state = S_IDLE;
                else if (len_cnt == '0)    next_state = S_GAP;
            end
            S_GAP: begin
                if (abort)                 next_state = S_IDLE;
                else if (len_cnt == '0)    next_state = last_pulse ? S_DONE : S_LOAD;
            end
            S_DONE:   next_state = S_IDLE;
            S_DRAIN:  if (to_hit || !ACK) next_state = S_IDLE;
            default:  next_state = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk_48 or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            REQ            <= 1'b0;
            start          <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pulse_idx      <= '0;
            prof_idx       <= '0;
            lat_nprof      <= '0;
            lat_burst      <= '0;
            lat_pulse      <= '0;
            lat_gap        <= '0;
            len_cnt        <= '0;
            DDS_freq       <= '0;
            DDS_delta_freq <= '0;
            DDS_delta_rate <= '0;
        end else begin
            state <= next_state;
            // Outputs are registered decodes of the state being entered.
            REQ   <= (next_state == S_REQ_HI);
            start <= (next_state == S_PULSE);
            busy  <= next_state inside {S_LOAD, S_REQ_HI, S_REQ_LO, S_PULSE, S_GAP, S_DRAIN};
            done  <= (next_state == S_DONE);

            if (go_ok) begin
                lat_nprof <= eff_nprof;
                lat_burst <= burst_cnt;
                lat_pulse <= eff_pulse;
                lat_gap   <= eff_gap;
                pulse_idx <= '0;
                prof_idx  <= '0;
            end else if (gap_end) begin
                pulse_idx <= pulse_next;
                prof_idx  <= prof_adv;
            end

            if (state == S_LOAD) begin
                DDS_freq       <= freq_tab[prof_idx];
                DDS_delta_freq <= dfreq_tab[prof_idx];
                DDS_delta_rate <= rate_tab[prof_idx];
            end

            if (state != S_PULSE && next_state == S_PULSE)
                len_cnt <= lat_pulse - CW'(1);
            else if (state == S_PULSE && next_state == S_GAP)
                len_cnt <= lat_gap - CW'(1);
            else if ((state inside {S_PULSE, S_GAP}) && len_cnt != '0)
                len_cnt <= len_cnt - CW'(1);
        end
    end

    // NOTE: the profile table is a register array with an async clear, because reset
    // must leave every profile at zero; it is small enough that no RAM macro is wanted.
    always_ff @(posedge clk_48 or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_PROF; i++) begin
                freq_tab[i]  <= '0;
                dfreq_tab[i] <= '0;
                rate_tab[i]  <= '0;
            end
        end else if (cfg_we) begin
            freq_tab[cfg_addr]  <= cfg_freq;
            dfreq_tab[cfg_addr] <= cfg_dfreq;
            rate_tab[cfg_addr]  <= cfg_rate;
        end
    end

`ifdef CHIRP_SCHED_ACK_TIMEOUT_EN
    localparam int TW = $clog2(ACK_TO + 1);

    logic [TW-1:0] to_cnt;

    // Fires in the cycle before the ACK_TO-th handshake edge, so the exit lands on it.
    assign to_hit = (state inside {S_REQ_HI, S_REQ_LO, S_DRAIN}) && (to_cnt == TW'(ACK_TO - 1));

    always_ff @(posedge clk_48 or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt <= '0;
            err    <= 1'b0;
        end else begin
            if (next_state != state)
                to_cnt <= '0;
            else if (state inside {S_REQ_HI, S_REQ_LO, S_DRAIN})
                to_cnt <= to_cnt + TW'(1);

            if (go_ok)
                err <= 1'b0;
            else if (to_hit && next_state == S_IDLE)
                err <= 1'b1;
        end
    end
`else
    assign to_hit = 1'b0;
    assign err    = 1'b0;
`endif

endmodule

// File: tb/tb_chirp_sched.sv
// Directed bench for chirp_sched; the timeout scenario runs when CHIRP_SCHED_ACK_TIMEOUT_EN is defined.
module tb_chirp_sched;

    localparam int N_PROF = 4;
    localparam int CW     = 24;
    localparam int ACK_TO = 16;

    logic        clk_48 = 1'b0;
    logic        rst_n;
    logic        cfg_we;
    logic [1:0]  cfg_addr;
    logic [47:0] cfg_freq;
    logic [47:0] cfg_dfreq;
    logic [31:0] cfg_rate;
    logic [2:0]  n_prof;
    logic [15:0] burst_cnt;
    logic [CW-1:0] pulse_len;
    logic [CW-1:0] gap_len;
    logic        go;
    logic        abort;
    logic        REQ;
    logic        ACK;
    logic [47:0] DDS_freq;
    logic [47:0] DDS_delta_freq;
    logic [31:0] DDS_delta_rate;
    logic        start;
    logic        busy;
    logic        done;
    logic [15:0] pulse_idx;
    logic        err;

    int tests = 0;
    int fails = 0;
    int done_seen = 0;

    logic [2:0] ack_sh = '0;
    bit         ack_auto = 1'b1;
    logic       ack_man = 1'b0;
    logic [47:0] pf [4];

    chirp_sched #(.N_PROF(N_PROF), .CW(CW), .ACK_TO(ACK_TO)) dut (
        .clk_48(clk_48), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_freq(cfg_freq), .cfg_dfreq(cfg_dfreq), .cfg_rate(cfg_rate),
        .n_prof(n_prof), .burst_cnt(burst_cnt), .pulse_len(pulse_len), .gap_len(gap_len),
        .go(go), .abort(abort), .REQ(REQ), .ACK(ACK),
        .DDS_freq(DDS_freq), .DDS_delta_freq(DDS_delta_freq), .DDS_delta_rate(DDS_delta_rate),
        .start(start), .busy(busy), .done(done), .pulse_idx(pulse_idx), .err(err)
    );

    always #5 clk_48 = ~clk_48;

    // DDS stand-in: ACK follows REQ three cycles late.
    always @(posedge clk_48) ack_sh <= {ack_sh[1:0], REQ};
    assign ACK = ack_auto ? ack_sh[2] : ack_man;

    always @(negedge clk_48) if (done === 1'b1) done_seen = done_seen + 1;

    task automatic tick();
        @(posedge clk_48);
        #1;
    endtask

    task automatic tick_n(input int n);
        repeat (n) tick();
    endtask

    task automatic write_prof(input int i, input logic [47:0] f, input logic [47:0] df, input logic [31:0] r);
        cfg_we = 1'b1; cfg_addr = 2'(i); cfg_freq = f; cfg_dfreq = df; cfg_rate = r;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic run_go(input logic [2:0] np, input logic [15:0] bc, input int pl, input int gl);
        n_prof = np; burst_cnt = bc; pulse_len = CW'(pl); gap_len = CW'(gl);
        go = 1'b1;
        tick();
        go = 1'b0;
    endtask

    task automatic wait_start(input logic lvl, input string name);
        int c = 0;
        while (start !== lvl && c < 200) begin tick(); c++; end
        tests++;
        if (start !== lvl) begin
            fails++;
            $display("FAIL %s: start=%b after %0d cycles, required %b", name, start, c, lvl);
        end
    endtask

    task automatic wait_idle(input string name);
        int c = 0;
        while (busy !== 1'b0 && c < 500) begin tick(); c++; end
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL %s: busy=%b after %0d cycles, required 0", name, busy, c);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_freq = '0; cfg_dfreq = '0; cfg_rate = '0;
        n_prof = '0; burst_cnt = '0; pulse_len = '0; gap_len = '0; go = 1'b0; abort = 1'b0;
        tick_n(3);
        tests++;
        if ({start, REQ, busy, done, err} !== 5'b0) begin
            fails++; $display("FAIL reset_ctrl: got %b required 00000", {start, REQ, busy, done, err});
        end
        tests++;
        if (DDS_freq !== 48'd0 || pulse_idx !== 16'd0) begin
            fails++; $display("FAIL reset_data: freq=%h idx=%0d required 0/0", DDS_freq, pulse_idx);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        int c, n, m, d0;
        write_prof(0, 48'h28F5C28F5C29, 48'h000000001000, 32'd7);
        d0 = done_seen;
        run_go(3'd1, 16'd1, 10, 5);
        tests++;
        if (REQ !== 1'b0 || busy !== 1'b1) begin
            fails++; $display("FAIL single_load: REQ=%b busy=%b required 0/1", REQ, busy);
        end
        tick();
        tests++;
        if (REQ !== 1'b1) begin fails++; $display("FAIL single_req_rise: REQ=%b required 1", REQ); end
        tests++;
        if (DDS_freq !== 48'h28F5C28F5C29 || DDS_delta_freq !== 48'h000000001000 || DDS_delta_rate !== 32'd7) begin
            fails++; $display("FAIL single_dds: %h %h %h required 28f5c28f5c29 000000001000 00000007",
                              DDS_freq, DDS_delta_freq, DDS_delta_rate);
        end
        c = 0;
        while (start !== 1'b1 && c < 100) begin tick(); c++; end
        tests++;
        if (c != 8) begin fails++; $display("FAIL single_req_to_start: %0d cycles, required 8", c); end
        n = 0;
        while (start === 1'b1 && n < 100) begin tick(); n++; end
        tests++;
        if (n != 10) begin fails++; $display("FAIL single_pulse_width: %0d cycles, required 10", n); end
        m = 0;
        while (done !== 1'b1 && m < 50) begin tick(); m++; end
        tests++;
        if (m != 5) begin fails++; $display("FAIL single_gap_to_done: %0d cycles, required 5", m); end
        tests++;
        if (busy !== 1'b0 || pulse_idx !== 16'd1) begin
            fails++; $display("FAIL single_done_state: busy=%b idx=%0d required 0/1", busy, pulse_idx);
        end
        tick();
        tests++;
        if (done !== 1'b0 || done_seen - d0 != 1) begin
            fails++; $display("FAIL single_done_once: done=%b count=%0d required 0/1", done, done_seen - d0);
        end
    endtask

    task automatic test_wrap();
        int d0;
        pf[0] = 48'h111111111111; pf[1] = 48'h222222222222;
        pf[2] = 48'h333333333333; pf[3] = 48'h444444444444;
        for (int i = 0; i < 4; i++) write_prof(i, pf[i], 48'(i + 1), 32'(i + 10));
        d0 = done_seen;
        run_go(3'd3, 16'd5, 3, 2);
        for (int i = 0; i < 5; i++) begin
            wait_start(1'b1, "wrap_start_rise");
            tests++;
            if (DDS_freq !== pf[i % 3] || pulse_idx !== 16'(i)) begin
                fails++; $display("FAIL wrap_pulse%0d: freq=%h idx=%0d required %h/%0d", i, DDS_freq, pulse_idx, pf[i % 3], i);
            end
            wait_start(1'b0, "wrap_start_fall");
        end
        wait_idle("wrap_idle");
        tick_n(2);
        tests++;
        if (done_seen - d0 != 1 || pulse_idx !== 16'd5) begin
            fails++; $display("FAIL wrap_end: dones=%0d idx=%0d required 1/5", done_seen - d0, pulse_idx);
        end
    endtask

    task automatic test_clamp();
        int n;
        run_go(3'd7, 16'd5, 1, 2);
        n_prof = 3'd1; pulse_len = CW'(50);
        for (int i = 0; i < 5; i++) begin
            wait_start(1'b1, "clamp_start_rise");
            tests++;
            if (DDS_freq !== pf[i % 4]) begin
                fails++; $display("FAIL clamp_pulse%0d: freq=%h required %h", i, DDS_freq, pf[i % 4]);
            end
            n = 0;
            while (start === 1'b1 && n < 100) begin tick(); n++; end
            if (i == 0) begin
                tests++;
                if (n != 2) begin fails++; $display("FAIL clamp_latched_width: %0d cycles, required 2", n); end
            end
        end
        wait_idle("clamp_idle");
        tick();
    endtask

    task automatic test_abort_pulse();
        int d0;
        d0 = done_seen;
        run_go(3'd1, 16'd3, 20, 5);
        wait_start(1'b1, "abort_pulse_rise");
        tick_n(3);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tests++;
        if (start !== 1'b0 || busy !== 1'b0 || REQ !== 1'b0) begin
            fails++; $display("FAIL abort_pulse: start=%b busy=%b REQ=%b required 000", start, busy, REQ);
        end
        tick_n(4);
        tests++;
        if (done_seen != d0 || start !== 1'b0) begin
            fails++; $display("FAIL abort_pulse_nodone: dones=%0d start=%b required 0/0", done_seen - d0, start);
        end
    endtask

    task automatic test_abort_req();
        int d0, bad;
        ack_auto = 1'b0; ack_man = 1'b0;
        d0 = done_seen;
        run_go(3'd1, 16'd1, 4, 4);
        tick();
        tick_n(2);
        tests++;
        if (REQ !== 1'b1 || busy !== 1'b1) begin
            fails++; $display("FAIL abort_req_wait: REQ=%b busy=%b required 1/1", REQ, busy);
        end
        ack_man = 1'b1; abort = 1'b1;
        tick();
        abort = 1'b0;
        tests++;
        if (REQ !== 1'b0 || busy !== 1'b1) begin
            fails++; $display("FAIL abort_req_drop: REQ=%b busy=%b required 0/1", REQ, busy);
        end
        bad = 0;
        repeat (6) begin
            tick();
            if (busy !== 1'b1 || REQ !== 1'b0 || start !== 1'b0) bad++;
        end
        tests++;
        if (bad != 0) begin fails++; $display("FAIL abort_req_drain: %0d bad cycles, required 0", bad); end
        ack_man = 1'b0;
        tick();
        tests++;
        if (busy !== 1'b0 || done_seen != d0) begin
            fails++; $display("FAIL abort_req_exit: busy=%b dones=%0d required 0/0", busy, done_seen - d0);
        end
        ack_auto = 1'b1;
        tick_n(4);
    endtask

    task automatic test_continuous();
        int d0, n, bad_idx, bad_freq, bad_w;
        d0 = done_seen; bad_idx = 0; bad_freq = 0; bad_w = 0;
        run_go(3'd0, 16'd0, 1, 0);
        for (int i = 0; i < 10; i++) begin
            wait_start(1'b1, "cont_start_rise");
            if (pulse_idx !== 16'(i)) bad_idx++;
            if (DDS_freq !== pf[0]) bad_freq++;
            if (i < 9) begin
                n = 0;
                while (start === 1'b1 && n < 20) begin tick(); n++; end
                if (n != 2) bad_w++;
            end
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tests++;
        if (bad_idx != 0 || bad_freq != 0 || bad_w != 0) begin
            fails++; $display("FAIL cont_pulses: idx=%0d freq=%0d width=%0d bad, required 0", bad_idx, bad_freq, bad_w);
        end
        tick_n(3);
        tests++;
        if (start !== 1'b0 || busy !== 1'b0 || pulse_idx !== 16'd9 || done_seen != d0) begin
            fails++; $display("FAIL cont_abort: start=%b busy=%b idx=%0d dones=%0d required 0/0/9/0",
                              start, busy, pulse_idx, done_seen - d0);
        end
    endtask

`ifdef CHIRP_SCHED_ACK_TIMEOUT_EN
    task automatic test_timeout();
        int bad, d0;
        ack_auto = 1'b0; ack_man = 1'b0;
        d0 = done_seen;
        run_go(3'd1, 16'd1, 4, 4);
        tick();
        bad = 0;
        repeat (15) begin
            tick();
            if (REQ !== 1'b1 || err !== 1'b0) bad++;
        end
        tests++;
        if (bad != 0) begin fails++; $display("FAIL timeout_early: %0d bad cycles, required 0", bad); end
        tick();
        tests++;
        if (err !== 1'b1 || REQ !== 1'b0 || busy !== 1'b0) begin
            fails++; $display("FAIL timeout_fire: err=%b REQ=%b busy=%b required 1/0/0", err, REQ, busy);
        end
        tick_n(3);
        tests++;
        if (err !== 1'b1 || done_seen != d0) begin
            fails++; $display("FAIL timeout_sticky: err=%b dones=%0d required 1/0", err, done_seen - d0);
        end
        ack_auto = 1'b1;
        run_go(3'd1, 16'd1, 4, 4);
        tests++;
        if (err !== 1'b0) begin fails++; $display("FAIL timeout_clear: err=%b required 0", err); end
        wait_idle("timeout_rerun_idle");
        tick();
    endtask
`else
    task automatic test_err_tied();
        tests++;
        if (err !== 1'b0) begin fails++; $display("FAIL err_tied: err=%b required 0", err); end
    endtask
`endif

    task automatic test_reset_mid();
        run_go(3'd1, 16'd0, 30, 4);
        wait_start(1'b1, "rstmid_start_rise");
        tick_n(2);
        #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if ({start, REQ, busy, done, err} !== 5'b0) begin
            fails++; $display("FAIL reset_mid_async: got %b required 00000", {start, REQ, busy, done, err});
        end
        tick();
        rst_n = 1'b1;
        tick();
        tests++;
        if (DDS_freq !== 48'd0 || pulse_idx !== 16'd0) begin
            fails++; $display("FAIL reset_mid_data: freq=%h idx=%0d required 0/0", DDS_freq, pulse_idx);
        end
        tick_n(4);
        run_go(3'd1, 16'd1, 3, 3);
        tick();
        tests++;
        if (REQ !== 1'b1 || DDS_freq !== 48'd0) begin
            fails++; $display("FAIL reset_mid_table: REQ=%b freq=%h required 1/0", REQ, DDS_freq);
        end
        wait_idle("reset_mid_idle");
    endtask

    initial begin
        test_reset();
        test_single();
        test_wrap();
        test_clamp();
        test_abort_pulse();
        test_abort_req();
        test_continuous();
`ifdef CHIRP_SCHED_ACK_TIMEOUT_EN
        test_timeout();
`else
        test_err_tied();
`endif
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/chirp_sched.md
Name: chirp_sched

Overview:
- Pulse sequencer in the clk_48 domain that drives the chirp DDS generator's parameter handshake and start line.
- Holds a small table of chirp profiles (start frequency, frequency step, step rate).
- For each pulse: delivers one profile over the 4-phase REQ/ACK handshake, holds start high for a programmed pulse length, then waits a programmed gap.
- Repeats for a burst of pulses, cycling through the active profiles.

Parameters:
- N_PROF, 4, number of profile table entries (power of 2, ≥2).
- CW, 24, width of the pulse/gap length counters.
- ACK_TO, 1024, handshake timeout in clk_48 cycles (used only with the optional feature).

Ports:
- clk_48  in  1  system clock, 48 MHz.
- rst_n  in  1  asynchronous active-low reset.
- cfg_we  in  1  profile table write strobe.
- cfg_addr  in  $clog2(N_PROF)  profile table write index.
- cfg_freq  in  48  profile start frequency word.
- cfg_dfreq  in  48  profile frequency step.
- cfg_rate  in  32  profile step-rate divider.
- n_prof  in  $clog2(N_PROF)+1  active profile count; 0 is treated as 1, values above N_PROF are clamped to N_PROF.
- burst_cnt  in  16  pulses per burst; 0 means continuous.
- pulse_len  in  CW  start-high length in cycles; values below 2 are treated as 2.
- gap_len  in  CW  start-low length after a pulse; values below 2 are treated as 2.
- go  in  1  launch burst (level sampled in IDLE).
- abort  in  1  stop burst.
- REQ  out  1  parameter transfer request to the DDS block.
- ACK  in  1  transfer acknowledge, already synchronised to clk_48.
- DDS_freq  out  48  profile start frequency.
- DDS_delta_freq  out  48  profile frequency step.
- DDS_delta_rate  out  32  profile step rate.
- start  out  1  DDS run enable.
- busy  out  1  burst in progress.
- done  out  1  one-cycle pulse at normal burst completion.
- pulse_idx  out  16  index of the current pulse within the burst.
- err  out  1  sticky handshake timeout flag.

Behaviour:
- Reset: state IDLE; every output is 0; the profile table is cleared to 0.
- All outputs are registered.
- Table writes: a write with cfg_we=1 lands at the clock edge and is accepted in any state. A profile is read only in LOAD, so a write made during a burst takes effect on the next LOAD of that entry.
- Control sampling: n_prof, burst_cnt, pulse_len and gap_len are latched when go is accepted. Later changes have no effect until the next burst.
- IDLE: when go=1, latch the controls, clear pulse_idx and profile index, clear err, set busy=1, and move to LOAD. go is ignored while busy=1.
- LOAD (1 cycle): DDS_freq, DDS_delta_freq and DDS_delta_rate are loaded from table[prof_idx]. Next state REQ_HI. REQ rises 2 cycles after the go cycle.
- REQ_HI: REQ=1; wait for ACK=1; then REQ=0 on the next cycle and go to REQ_LO.
- REQ_LO: wait for ACK=0; then start=1 on the next cycle and go to PULSE.
- DDS_* outputs stay stable from LOAD until the next LOAD.
- PULSE: start is high for exactly the effective pulse_len cycles, then goes low; go to GAP.
- GAP: start is low for exactly the effective gap_len cycles. At the end, pulse_idx increments (16-bit wrap) and prof_idx advances modulo the effective n_prof.
  - If burst_cnt≠0 and the completed pulse count equals burst_cnt: go to DONE.
  - Otherwise go to LOAD.
- DONE (1 cycle): done=1, busy=0, next state IDLE. pulse_idx holds its last value until the next go.
- Abort in LOAD, PULSE or GAP: the next cycle has start=0 and REQ=0, state IDLE, busy=0, and no done pulse.
- Abort in REQ_HI or REQ_LO: REQ=0 the next cycle; stay in an internal DRAIN state until ACK=0; then IDLE with busy=0 and no done. The 4-phase protocol is never broken.
- Simultaneous events: abort wins over every other event, including a same-cycle ACK edge or gap expiry.
- Reset mid-operation: start and REQ drop asynchronously, the burst is lost, and the table is cleared.

Optional Feature:
- Macro: CHIRP_SCHED_ACK_TIMEOUT_EN.
- When defined:
  - A counter runs in REQ_HI, REQ_LO and DRAIN, and clears on every state change.
  - If the counter reaches ACK_TO: err=1 (sticky until the next accepted go), REQ=0, busy=0, state IDLE, no done.
- When undefined: no counter, the handshake waits indefinitely, and err is tied 0.

Test Plan:
- Reset: assert rst_n=0 mid-PULSE → start, REQ, busy, done and err are all 0 immediately; after release, DDS_freq=0.
- Single pulse: n_prof=1, burst_cnt=1, pulse_len=10, gap_len=5, table[0].freq=48'h28F5C28F5C29, ACK echoes REQ after 3 cycles → REQ rises at go+2, start is high for 10 cycles, done fires 5 cycles after start falls, DDS_freq matches the table.
- Profile wrap: n_prof=3, burst_cnt=5, distinct profiles → DDS_freq sequence p0,p1,p2,p0,p1; pulse_idx 0..4; exactly one done.
- Abort: abort in PULSE → start=0 next cycle, busy=0, no done. Abort in REQ_HI with ACK held high 6 more cycles → REQ=0 next cycle, busy stays 1 until ACK falls, then 0.
- Continuous and clamping: burst_cnt=0, pulse_len=1 → start-high width is 2 cycles; run 10 pulses, then abort → no done, pulse_idx=9.
- Timeout (macro defined, ACK_TO=16): ACK stuck at 0 → err=1 and REQ=0 exactly 16 cycles after REQ rises; the next go clears err.
